// File: rtl/stack_pkg.sv
// stack_pkg: shared types and helpers for the stack controller.
//   stack_op_t  - operation codes offered on op_code (code 7 decodes as NOP)
//   state_t     - controller FSM states, also exported for debug
//   decode_op   - maps the raw 3-bit op_code onto stack_op_t
//   beat_count  - memory beats an operation needs (2 for INT/RTI, else 1)
//   is_push_op / is_pop_op - classify an operation by stack direction
package stack_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_PUSH = 3'd1,
        OP_POP  = 3'd2,
        OP_CALL = 3'd3,
        OP_RET  = 3'd4,
        OP_INT  = 3'd5,
        OP_RTI  = 3'd6
    } stack_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    function automatic stack_op_t decode_op(input logic [2:0] code);
        stack_op_t op;
        case (code)
            3'd1:    op = OP_PUSH;
            3'd2:    op = OP_POP;
            3'd3:    op = OP_CALL;
            3'd4:    op = OP_RET;
            3'd5:    op = OP_INT;
            3'd6:    op = OP_RTI;
            default: op = OP_NOP;   // 0 and the reserved code 7
        endcase
        return op;
    endfunction

    function automatic logic [1:0] beat_count(input stack_op_t op);
        return (op == OP_INT || op == OP_RTI) ? 2'd2 : 2'd1;
    endfunction

    function automatic logic is_push_op(input stack_op_t op);
        return (op == OP_PUSH || op == OP_CALL || op == OP_INT);
    endfunction

    function automatic logic is_pop_op(input stack_op_t op);
        return (op == OP_POP || op == OP_RET || op == OP_RTI);
    endfunction

endpackage

// File: rtl/stack_ctrl_if.sv
// stack_ctrl_if: single-port data-memory request/ack bus.
//   mem_req   - request outstanding
//   mem_we    - 1 = write, 0 = read
//   mem_addr  - address
//   mem_wdata - write data
//   mem_rdata - read data, valid in the mem_ack cycle
//   mem_ack   - request completes at the next rising edge
// Handshake: once mem_req rises, mem_req/mem_we/mem_addr/mem_wdata hold
// steady until the cycle in which mem_ack is high; that cycle's rising
// edge retires the request.
interface stack_ctrl_if #(
    parameter int WIDTH = 8
) ();
    logic             mem_req;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;
    logic             mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/stack_ctrl.sv
// stack_ctrl: sequences PUSH/POP/CALL/RET/INT/RTI for the 8-bit core and
// owns the registered stack pointer. The stack grows down from SP_RESET.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   op_valid/op_ready   - operation offer / accept (accept only in IDLE)
//   op_code             - raw stack_op_t code
//   push_data, pc_in, flags_in - operands sampled on accept
//   mem                 - memory bus (master side)
//   sp                  - current stack pointer
//   pop_data/pop_valid  - POP result and strobe
//   pc_out/pc_load      - restored PC and strobe (RET, RTI)
//   flags_out/flags_load- restored flags and strobe (RTI)
//   done, stk_err       - completion strobe, overflow/underflow strobe
//   fsm_state           - current FSM state for debug
module stack_ctrl
    import stack_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter int               FLAG_W   = 4,
    parameter logic [WIDTH-1:0] SP_RESET = 8'hFF,
    parameter logic [WIDTH-1:0] SP_LIMIT = 8'h80
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    input  logic [2:0]        op_code,
    output logic              op_ready,
    input  logic [WIDTH-1:0]  push_data,
    input  logic [WIDTH-1:0]  pc_in,
    input  logic [FLAG_W-1:0] flags_in,
    stack_ctrl_if.master      mem,
    output logic [WIDTH-1:0]  sp,
    output logic [WIDTH-1:0]  pop_data,
    output logic              pop_valid,
    output logic [WIDTH-1:0]  pc_out,
    output logic              pc_load,
    output logic [FLAG_W-1:0] flags_out,
    output logic              flags_load,
    output logic              done,
    output logic              stk_err,
    output state_t            fsm_state
);

    state_t            state_q, state_d;
    stack_op_t         op_q, op_d, acc_op;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [WIDTH-1:0]  pc_q, pc_d;
    logic [FLAG_W-1:0] flg_q, flg_d;
    logic [WIDTH-1:0]  sp_q, sp_d;
    logic              beat_q, beat_d;   // 0 = first beat, 1 = second beat
    logic              err_q, err_d;
    logic [WIDTH-1:0]  pop_q, pop_d;
    logic [WIDTH-1:0]  pco_q, pco_d;
    logic [FLAG_W-1:0] flo_q, flo_d;
    int                space, entries, beats;
    logic              overflow, underflow;

    assign acc_op = decode_op(op_code);

    // Free slots and stacked entries, evaluated in int so that an SP
    // outside the legal window reads as "not enough" instead of wrapping.
    always_comb begin
        beats     = int'(beat_count(acc_op));
        space     = int'(sp_q) - int'(SP_LIMIT) + 1;
        entries   = int'(SP_RESET) - int'(sp_q);
        overflow  = is_push_op(acc_op) && (space < beats);
        underflow = is_pop_op(acc_op) && (entries < beats);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_NOP;
            data_q  <= '0;
            pc_q    <= '0;
            flg_q   <= '0;
            sp_q    <= SP_RESET;
            beat_q  <= 1'b0;
            err_q   <= 1'b0;
            pop_q   <= '0;
            pco_q   <= '0;
            flo_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            pc_q    <= pc_d;
            flg_q   <= flg_d;
            sp_q    <= sp_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
            pop_q   <= pop_d;
            pco_q   <= pco_d;
            flo_q   <= flo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        pc_d    = pc_q;
        flg_d   = flg_q;
        sp_d    = sp_q;
        beat_d  = beat_q;
        err_d   = err_q;
        pop_d   = pop_q;
        pco_d   = pco_q;
        flo_d   = flo_q;
        case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    op_d   = acc_op;
                    data_d = push_data;
                    pc_d   = pc_in;
                    flg_d  = flags_in;
                    beat_d = 1'b0;
                    err_d  = overflow || underflow;
                    if (overflow || underflow)  state_d = S_FIN;
                    else if (is_push_op(acc_op)) state_d = S_WR;
                    else if (is_pop_op(acc_op))  state_d = S_RD;
                    else                         state_d = S_FIN;
                end
            end
            S_WR: begin
                if (mem.mem_ack) begin
                    sp_d = sp_q - 1'b1;
                    if (op_q == OP_INT && !beat_q) beat_d  = 1'b1;
                    else                           state_d = S_FIN;
                end
            end
            S_RD: begin
                if (mem.mem_ack) begin
                    sp_d = sp_q + 1'b1;
                    if (op_q == OP_RTI && !beat_q) begin
                        // RTI pops flags first, PC on the second beat.
                        flo_d  = mem.mem_rdata[FLAG_W-1:0];
                        beat_d = 1'b1;
                    end else begin
                        if (op_q == OP_POP) pop_d = mem.mem_rdata;
                        else                pco_d = mem.mem_rdata;
                        state_d = S_FIN;
                    end
                end
            end
            default: state_d = S_IDLE;   // S_FIN
        endcase
    end

    // Push writes mem[SP] then decrements; pop reads mem[SP+1] then increments.
    always_comb begin
        mem.mem_req   = (state_q == S_WR) || (state_q == S_RD);
        mem.mem_we    = (state_q == S_WR);
        mem.mem_addr  = (state_q == S_RD) ? sp_q + 1'b1 : sp_q;
        if (op_q == OP_PUSH)            mem.mem_wdata = data_q;
        else if (op_q == OP_INT && beat_q) mem.mem_wdata = WIDTH'(flg_q);
        else                            mem.mem_wdata = pc_q;
    end

    assign op_ready   = (state_q == S_IDLE);
    assign done       = (state_q == S_FIN);
    assign stk_err    = done && err_q;
    assign pop_valid  = done && !err_q && (op_q == OP_POP);
    assign pc_load    = done && !err_q && (op_q == OP_RET || op_q == OP_RTI);
    assign flags_load = done && !err_q && (op_q == OP_RTI);
    assign sp         = sp_q;
    assign pop_data   = pop_q;
    assign pc_out     = pco_q;
    assign flags_out  = flo_q;
    assign fsm_state  = state_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: table of operations with expected SP/error/latency,
// a behavioural stack model feeding write and result scoreboards, and
// hand sequences for reset, stray ack, overflow and mid-operation reset.
module tb_stack_ctrl;
    import stack_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       op_valid = 1'b0;
    logic [2:0] op_code = 3'd0;
    logic [7:0] push_data = 8'h0, pc_in = 8'h0;
    logic [3:0] flags_in = 4'h0;
    logic       op_ready, pop_valid, pc_load, flags_load, done, stk_err;
    logic [7:0] sp, pop_data, pc_out;
    logic [3:0] flags_out;
    state_t     fsm_state;

    stack_ctrl_if #(.WIDTH(8)) mem_if ();

    stack_ctrl dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code),
        .op_ready(op_ready), .push_data(push_data), .pc_in(pc_in),
        .flags_in(flags_in), .mem(mem_if), .sp(sp), .pop_data(pop_data),
        .pop_valid(pop_valid), .pc_out(pc_out), .pc_load(pc_load),
        .flags_out(flags_out), .flags_load(flags_load), .done(done),
        .stk_err(stk_err), .fsm_state(fsm_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- model / scoreboards ----------------
    logic [7:0]  model_mem [256];
    logic [7:0]  model_sp;
    logic [15:0] wr_exp_q[$];   // {addr, data} of expected writes
    logic [23:0] exp_q[$];      // {err,pv,pl,fl,pop,pc,flags} per completion

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        op_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        model_sp = 8'hFF;
        wr_exp_q.delete();
        exp_q.delete();
    endtask

    // ---------------- memory responder ----------------
    int         ack_delay = 0;
    logic       stray_ack = 1'b0;
    int         wait_cnt = 0;
    logic [7:0] tb_mem [256];
    logic [16:0] lat_req;

    initial begin
        mem_if.mem_ack   = 1'b0;
        mem_if.mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (mem_if.mem_req) begin
                if (wait_cnt == 0)
                    lat_req = {mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata};
                else
                    chk("req_stable", {15'h0, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata},
                        {15'h0, lat_req});
                if (wait_cnt >= ack_delay) begin
                    mem_if.mem_ack = 1'b1;
                    wait_cnt = 0;
                    if (mem_if.mem_we) begin
                        if (wr_exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_write: got %0h=%0h expected none",
                                     mem_if.mem_addr, mem_if.mem_wdata);
                        end else begin
                            chk("mem_write", {16'h0, mem_if.mem_addr, mem_if.mem_wdata},
                                {16'h0, wr_exp_q.pop_front()});
                        end
                        tb_mem[mem_if.mem_addr] = mem_if.mem_wdata;
                    end else begin
                        mem_if.mem_rdata = tb_mem[mem_if.mem_addr];
                    end
                end else begin
                    mem_if.mem_ack = 1'b0;
                    wait_cnt++;
                end
            end else begin
                mem_if.mem_ack = stray_ack;
                wait_cnt = 0;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic do_op(input logic [2:0] code, input logic [7:0] d, input logic [7:0] pc,
                         input logic [3:0] fl, input int dly, output int lat);
        int         b;
        logic       err, pv, pl, fv;
        logic [7:0] pval, pcv;
        logic [3:0] flv;
        logic [23:0] got, exp;
        int         c;
        b = (code == 3'd5 || code == 3'd6) ? 2 : 1;
        err = 0; pv = 0; pl = 0; fv = 0; pval = 0; pcv = 0; flv = 0;
        if (code == 3'd1 || code == 3'd3 || code == 3'd5) begin
            if (int'(model_sp) - 128 + 1 < b) err = 1;
            else begin
                model_mem[model_sp] = (code == 3'd1) ? d : pc;
                wr_exp_q.push_back({model_sp, model_mem[model_sp]});
                model_sp = model_sp - 8'd1;
                if (code == 3'd5) begin
                    model_mem[model_sp] = {4'h0, fl};
                    wr_exp_q.push_back({model_sp, 4'h0, fl});
                    model_sp = model_sp - 8'd1;
                end
            end
        end else if (code == 3'd2 || code == 3'd4 || code == 3'd6) begin
            if (255 - int'(model_sp) < b) err = 1;
            else begin
                model_sp = model_sp + 8'd1;
                if (code == 3'd2) begin pv = 1; pval = model_mem[model_sp]; end
                else if (code == 3'd4) begin pl = 1; pcv = model_mem[model_sp]; end
                else begin
                    fv = 1; flv = model_mem[model_sp][3:0];
                    model_sp = model_sp + 8'd1;
                    pl = 1; pcv = model_mem[model_sp];
                end
            end
        end
        exp_q.push_back({err, pv, pl, fv, pval, pcv, flv});

        @(negedge clk);
        ack_delay = dly;
        op_valid = 1'b1; op_code = code; push_data = d; pc_in = pc; flags_in = fl;
        chk("ready_idle", {31'h0, op_ready}, 32'h1);
        @(posedge clk);
        #1;
        op_valid  = 1'b0;
        push_data = 8'($urandom_range(0, 255));
        pc_in     = 8'($urandom_range(0, 255));
        flags_in  = 4'($urandom_range(0, 15));
        lat = 0;
        c = 0;
        while (1) begin
            @(negedge clk);
            c++;
            if (done) begin
                lat = c;
                got = {stk_err, pop_valid, pc_load, flags_load,
                       pop_valid ? pop_data : 8'h00, pc_load ? pc_out : 8'h00,
                       flags_load ? flags_out : 4'h0};
                exp = exp_q.pop_front();
                chk("result", {8'h0, got}, {8'h0, exp});
                chk("sp_model", {24'h0, sp}, {24'h0, model_sp});
                break;
            end
            chk("ready_busy", {31'h0, op_ready}, 32'h0);
            if (c > 60) begin
                checks++;
                errors++;
                $display("FAIL done_timeout: got no done expected done within 60 cycles");
                void'(exp_q.pop_front());
                break;
            end
        end
        @(negedge clk);
        chk("ready_after", {31'h0, op_ready}, 32'h1);
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [2:0] code;
        logic [7:0] d;
        logic [7:0] pc;
        logic [3:0] fl;
        int         dly;
        logic [7:0] exp_sp;
        logic       exp_err;
        int         exp_lat;
    } vec_t;

    vec_t vecs[19];

    initial begin
        int lat;
        vecs[0]  = '{3'd1, 8'h3C, 8'h00, 4'h0, 0, 8'hFE, 1'b0, 2};  // PUSH 3C
        vecs[1]  = '{3'd2, 8'h00, 8'h00, 4'h0, 0, 8'hFF, 1'b0, 2};  // POP -> 3C
        vecs[2]  = '{3'd2, 8'h00, 8'h00, 4'h0, 0, 8'hFF, 1'b1, 1};  // POP underflow
        vecs[3]  = '{3'd4, 8'h00, 8'h00, 4'h0, 0, 8'hFF, 1'b1, 1};  // RET underflow
        vecs[4]  = '{3'd6, 8'h00, 8'h00, 4'h0, 0, 8'hFF, 1'b1, 1};  // RTI underflow
        vecs[5]  = '{3'd3, 8'h00, 8'h55, 4'h0, 1, 8'hFE, 1'b0, 3};  // CALL 55
        vecs[6]  = '{3'd1, 8'h77, 8'h00, 4'h0, 2, 8'hFD, 1'b0, 4};  // PUSH 77
        vecs[7]  = '{3'd4, 8'h00, 8'h00, 4'h0, 0, 8'hFE, 1'b0, 2};  // RET -> 77
        vecs[8]  = '{3'd4, 8'h00, 8'h00, 4'h0, 1, 8'hFF, 1'b0, 3};  // RET -> 55
        vecs[9]  = '{3'd5, 8'h00, 8'h42, 4'hA, 3, 8'hFD, 1'b0, 9};  // INT 42/A
        vecs[10] = '{3'd6, 8'h00, 8'h00, 4'h0, 3, 8'hFF, 1'b0, 9};  // RTI
        vecs[11] = '{3'd0, 8'h00, 8'h00, 4'h0, 0, 8'hFF, 1'b0, 1};  // NOP
        vecs[12] = '{3'd7, 8'h00, 8'h00, 4'h0, 0, 8'hFF, 1'b0, 1};  // reserved
        vecs[13] = '{3'd1, 8'h12, 8'h00, 4'h0, 0, 8'hFE, 1'b0, 2};  // PUSH 12
        vecs[14] = '{3'd5, 8'h00, 8'h9A, 4'h5, 1, 8'hFC, 1'b0, 5};  // INT 9A/5
        vecs[15] = '{3'd6, 8'h00, 8'h00, 4'h0, 0, 8'hFE, 1'b0, 3};  // RTI
        vecs[16] = '{3'd2, 8'h00, 8'h00, 4'h0, 0, 8'hFF, 1'b0, 2};  // POP -> 12
        vecs[17] = '{3'd5, 8'h00, 8'hC3, 4'hF, 0, 8'hFD, 1'b0, 3};  // INT C3/F
        vecs[18] = '{3'd6, 8'h00, 8'h00, 4'h0, 2, 8'hFF, 1'b0, 7};  // RTI

        do_reset();
        @(negedge clk);
        chk("rst_sp",       {24'h0, sp}, 32'hFF);
        chk("rst_ready",    {31'h0, op_ready}, 32'h1);
        chk("rst_state",    {30'h0, fsm_state}, {30'h0, S_IDLE});
        chk("rst_strobes",  {26'h0, mem_if.mem_req, done, stk_err, pop_valid, pc_load, flags_load}, 32'h0);
        chk("rst_data",     {12'h0, pop_data, pc_out, flags_out}, 32'h0);

        for (int i = 0; i < 19; i++) begin
            do_op(vecs[i].code, vecs[i].d, vecs[i].pc, vecs[i].fl, vecs[i].dly, lat);
            chk($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
            chk($sformatf("vec%0d_sp", i), {24'h0, sp}, {24'h0, vecs[i].exp_sp});
            chk($sformatf("vec%0d_err_model", i), {31'h0, exp_q.size() == 0}, 32'h1);
        end

        // ack while idle must be ignored
        stray_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stray_ack_idle", {23'h0, done, sp}, 32'hFF);
        end
        stray_ack = 1'b0;

        // fill the stack to the limit, then overflow
        for (int i = 0; i < 128; i++)
            do_op(3'd1, 8'($urandom_range(0, 255)), 8'h00, 4'h0, $urandom_range(0, 1), lat);
        chk("full_sp", {24'h0, sp}, 32'h7F);
        do_op(3'd1, 8'hEE, 8'h00, 4'h0, 0, lat);
        chk("ovf_lat", lat, 1);
        chk("ovf_sp", {24'h0, sp}, 32'h7F);
        do_op(3'd2, 8'h00, 8'h00, 4'h0, 0, lat);
        chk("pop_to_80", {24'h0, sp}, 32'h80);
        do_op(3'd5, 8'h00, 8'h11, 4'h3, 0, lat);
        chk("int_ovf_lat", lat, 1);
        chk("int_ovf_sp", {24'h0, sp}, 32'h80);
        chk("no_pending_wr", wr_exp_q.size(), 0);

        // reset during a CALL write wait
        do_reset();
        @(negedge clk);
        ack_delay = 20;
        op_valid = 1'b1; op_code = 3'd3; pc_in = 8'h66;
        @(posedge clk);
        #1 op_valid = 1'b0;
        @(negedge clk);
        chk("call_req", {31'h0, mem_if.mem_req}, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_req",   {31'h0, mem_if.mem_req}, 32'h0);
        chk("mid_rst_sp",    {24'h0, sp}, 32'hFF);
        chk("mid_rst_state", {30'h0, fsm_state}, {30'h0, S_IDLE});
        chk("mid_rst_ready", {31'h0, op_ready}, 32'h1);
        chk("mid_rst_done",  {31'h0, done}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_quiet", {30'h0, done, mem_if.mem_req}, 32'h0);
        end
        model_sp = 8'hFF;
        wr_exp_q.delete();
        exp_q.delete();
        do_op(3'd1, 8'h5A, 8'h00, 4'h0, 0, lat);
        chk("post_rst_push_sp", {24'h0, sp}, 32'hFE);
        chk("post_rst_push_lat", lat, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
- Sequences all stack traffic for the 8-bit pipelined core: PUSH, POP, CALL, RET, INT and RTI.
- Owns the registered stack pointer (SP), so the register file no longer needs its combinational inc/dec path.
- Drives a single-port data-memory request/ack interface.
- Returns popped data, PC and flags to the pipeline with one-cycle load strobes.

Parameters:
- WIDTH, 8: data, address and SP width.
- FLAG_W, 4: width of the flags word saved by INT and restored by RTI; zero-extended to WIDTH in memory.
- SP_RESET, 8'hFF: SP value after reset; this is also the empty-stack value. The stack grows down.
- SP_LIMIT, 8'h80: lowest writable stack address. A push with SP == SP_LIMIT-1 is an overflow.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- op_valid, input, 1: a stack operation is offered.
- op_code, input, 3: stack_op_t (NOP, PUSH, POP, CALL, RET, INT, RTI).
- op_ready, output, 1: controller can accept an operation; high only in IDLE.
- push_data, input, WIDTH: PUSH operand, sampled on accept.
- pc_in, input, WIDTH: return PC for CALL/INT, sampled on accept.
- flags_in, input, FLAG_W: flags for INT, sampled on accept.
- mem_req, output, 1: memory request.
- mem_we, output, 1: 1 = write, 0 = read.
- mem_addr, output, WIDTH: memory address.
- mem_wdata, output, WIDTH: write data.
- mem_rdata, input, WIDTH: read data, valid in the mem_ack cycle.
- mem_ack, input, 1: request completes this cycle.
- sp, output, WIDTH: current SP (registered).
- pop_data, output, WIDTH: POP result.
- pop_valid, output, 1: one-cycle strobe qualifying pop_data.
- pc_out, output, WIDTH: restored PC.
- pc_load, output, 1: one-cycle strobe for RET/RTI.
- flags_out, output, FLAG_W: restored flags.
- flags_load, output, 1: one-cycle strobe for RTI.
- done, output, 1: one-cycle strobe when any operation completes, including error completions.
- stk_err, output, 1: one-cycle strobe on overflow or underflow.

Behaviour:
- Reset: state IDLE; sp = SP_RESET; all other outputs 0. Reset applies mid-operation: any outstanding mem_req is dropped, captured operands are discarded, and SP does not change.
- Accept: op_valid && op_ready at a rising edge latches op_code, push_data, pc_in and flags_in.
  - NOP is accepted and completes with done the next cycle, with no memory access.
- Push semantics (post-decrement): write mem[SP], then SP <= SP-1 on ack.
  - PUSH writes push_data; CALL writes pc_in.
  - INT writes pc_in first, then flags_in zero-extended.
- Pop semantics (pre-increment): read mem[SP+1], then SP <= SP+1 on ack.
  - POP returns pop_data; RET returns pc_out.
  - RTI pops flags first, then PC.
- FSM states:
  - IDLE -> WR on a push-type op.
  - IDLE -> RD on a pop-type op.
  - IDLE -> FIN on NOP or on a detected error.
  - WR/RD -> same state for the second beat of INT/RTI.
  - WR/RD -> FIN after the final ack.
  - FIN -> IDLE unconditionally.
- FIN drives done plus the relevant strobes.
- In WR/RD, mem_req stays high, and mem_addr, mem_we and mem_wdata stay stable, until mem_ack.
- SP and the beat counter update only on an ack edge.
- Latency with zero-wait memory (ack in the first WR/RD cycle):
  - Single-beat op: accept at edge 0, request in cycle 1, done in cycle 2, op_ready high again in cycle 3.
  - INT/RTI: done in cycle 3.
  - Each ack-wait cycle adds one cycle.
- Overflow: a push-type op where the remaining space is smaller than the beats needed (SP - SP_LIMIT + 1 < beats).
- Underflow: a pop-type op where the stacked entries are fewer than the beats needed (SP_RESET - SP < beats).
- Error handling: errors are checked at accept. On error there is no mem_req, SP is unchanged, and FIN asserts done and stk_err with no data strobes. A partial INT/RTI never occurs.
- Arithmetic: SP math is modulo 2^WIDTH. The error checks prevent wrap in legal configurations.
- mem_ack is ignored outside WR/RD.

Decomposition:
- stack_pkg:
  - stack_op_t enum with encodings NOP=0, PUSH=1, POP=2, CALL=3, RET=4, INT=5, RTI=6; 7 is reserved and treated as NOP.
  - state_t enum (IDLE, WR, RD, FIN).
  - Beat-count function: 2 for INT/RTI, otherwise 1.
- Single module; no sub-module is needed.

Test Plan:
- Reset, then PUSH 8'h3C with 0-wait ack -> mem write addr FF data 3C; sp = FE; done in cycle 2; op_ready low in cycles 1-2.
- Continue with POP -> read addr FF with mem_rdata 3C -> pop_data = 3C with pop_valid pulse; sp = FF.
- POP straight after reset -> no mem_req; stk_err and done pulse together; sp stays FF.
- INT with pc_in 42 and flags_in A, ack delayed 3 cycles on each beat -> writes FF=42 then FE=0A, with address and data stable throughout the waits; sp = FD. Then RTI -> flags_out = A (flags_load), pc_out = 42 (pc_load); sp = FF.
- Push until sp = 7F (128 PUSHes) -> the next PUSH gives stk_err with no write. With sp = 80, INT -> stk_err, sp unchanged, no partial write.
- Assert rst during the CALL WR wait -> next cycle mem_req = 0, sp = FF, state IDLE, op_ready = 1, no done pulse.
